rf_write_buffer: RTL

- Posted-write queue directly upstream of mips_regfile: accepts register-write requests from the execute/writeback side, holds up to DEPTH of them, and drains one per cycle into the regfile write port (wr_regnum/wr_data/enable).
- Forwards pending (not yet drained) values on both read ports, so a reader never sees stale regfile data while a write to the same register is still queued.
- Exists so that a stalled write port (shared with other writers) does not stall the producer.

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_fwd_match.sv | 41 ++++
 rtl/rf_write_buffer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write path.
//   REG_W / DATA_W : register-number and data widths of the regfile port
//   ZERO_REG       : hard-wired zero register, never written
//   rf_wr_t        : one register write {regnum, data}; used for queue
//                    entries and for the regfile write bundle
package rf_pkg;

   localparam int unsigned      REG_W    = 5;
   localparam int unsigned      DATA_W   = 32;
   localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic [REG_W-1:0]  regnum;
      logic [DATA_W-1:0] data;
   } rf_wr_t;

endpackage

// File: rtl/rf_fwd_match.sv
// Newest-match search over the pending write queue for one read port.
//   entries : queue storage (only head..head+count-1 are valid)
//   head    : oldest valid slot
//   count   : number of valid slots
//   regnum  : register being read
//   hit     : a valid entry targets regnum (never for the zero register)
//   data    : data of the newest such entry, 0 when no hit
module rf_fwd_match
   import rf_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  rf_wr_t                     entries [DEPTH],
   input  logic [$clog2(DEPTH)-1:0]   head,
   input  logic [$clog2(DEPTH+1)-1:0] count,
   input  logic [REG_W-1:0]           regnum,
   output logic                       hit,
   output logic [DATA_W-1:0]          data
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW-1:0] idx;

   // Walk from tail-1 (newest) back towards head; first match wins.
   // count[PW-1:0] is 0 when full, which still lands tail-1 on head-1 mod DEPTH.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head + count[PW-1:0] - PW'(1) - PW'(i);
         if (!hit && (i < 32'(count)) && (regnum != ZERO_REG) &&
             (entries[idx].regnum == regnum)) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
   end

endmodule

// File: rtl/rf_write_buffer.sv
// Posted-write queue in front of the register file.
// Accepts register writes from the producer, holds up to DEPTH of them and
// drains one per cycle into the regfile write port whenever drain_en is high.
// Both read ports are forwarded from the newest pending write to the same
// register so readers never observe stale regfile contents.
//   clk, reset                 : clock, synchronous active-high reset
//   in_valid/in_ready          : producer handshake
//   in_regnum/in_data          : write request (register 0 is accepted, dropped)
//   drain_en                   : regfile write port free this cycle
//   wr_regnum/wr_data/wr_enable: regfile write port
//   rdN_regnum, rf_rdN_data    : read address and raw regfile data
//   rdN_data                   : forwarded read data
//   count/full/empty           : occupancy status
module rf_write_buffer
   import rf_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned REGW  = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [REGW-1:0]            in_regnum,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       drain_en,
   output logic [REGW-1:0]            wr_regnum,
   output logic [WIDTH-1:0]           wr_data,
   output logic                       wr_enable,
   input  logic [REGW-1:0]            rd1_regnum,
   input  logic [REGW-1:0]            rd2_regnum,
   input  logic [WIDTH-1:0]           rf_rd1_data,
   input  logic [WIDTH-1:0]           rf_rd2_data,
   output logic [WIDTH-1:0]           rd1_data,
   output logic [WIDTH-1:0]           rd2_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   rf_wr_t        mem_q [DEPTH];
   rf_wr_t        mem_d [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;
   logic          hit1, hit2;
   logic [DATA_W-1:0] fwd1, fwd2;

   rf_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
      .entries (mem_q),
      .head    (head_q),
      .count   (count_q),
      .regnum  (rd1_regnum),
      .hit     (hit1),
      .data    (fwd1)
   );

   rf_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
      .entries (mem_q),
      .head    (head_q),
      .count   (count_q),
      .regnum  (rd2_regnum),
      .hit     (hit2),
      .data    (fwd2)
   );

   always_comb begin
      count    = count_q;
      full     = (count_q == CW'(DEPTH));
      empty    = (count_q == '0);
      in_ready = !reset && (!full || drain_en);
      push     = in_valid && in_ready && (in_regnum != '0);
      pop      = !reset && drain_en && !empty;
      wr_enable = pop;

      wr_regnum = '0;
      wr_data   = '0;
      if (!reset && !empty) begin
         wr_regnum = mem_q[head_q].regnum;
         wr_data   = mem_q[head_q].data;
      end

      rd1_data = hit1 ? fwd1 : rf_rd1_data;
      rd2_data = hit2 ? fwd2 : rf_rd2_data;

      // When full with push+pop, tail == head: the slot is overwritten at the
      // same edge the regfile captures its old contents, which is safe.
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop) begin
         head_d = head_q + PW'(1);
      end
      if (push) begin
         mem_d[tail_q] = '{regnum: in_regnum, data: in_data};
         tail_d        = tail_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage is not reset; validity is carried by head/count alone.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule
